// File: rtl/equiv_pkg.sv
// Shared types and constants for the equivalence-check sweep controller.
package equiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DONE
    } state_t;

    localparam int N_IN_DEF        = 5;
    localparam int HOLD_CYCLES_DEF = 3;

    function automatic int unsigned vec_count(input int unsigned n_in);
        return 2 ** n_in;
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Per-vector settle timer: expire marks the last cycle a vector is held.
module sweep_hold_timer #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count < LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive ascending input sweep with per-vector settle window; samples eq_in
// at the end of each window and reports mismatch count and first failing vector.
module equiv_sweep_ctrl
    import equiv_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            eq_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int unsigned     NVEC     = vec_count(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);
    localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

    state_t state;
    state_t state_next;
    logic   expire;
    logic   sample;
    logic   launch;

    // Timer is held clear outside HOLD so every sweep starts at count zero.
    sweep_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear ((state != HOLD) || expire || abort),
        .enable(state == HOLD),
        .expire(expire)
    );

    assign sample = (state == HOLD) && !abort && expire;
    assign launch = (state != HOLD) && start && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (expire && (vec_out == LAST_VEC)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == HOLD);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_out          <= '0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (launch) begin
            vec_out          <= '0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if ((state == HOLD) && abort) begin
            // Partial counts and first-fail data are kept for debug.
            vec_out <= '0;
            pass    <= 1'b0;
        end else if (sample) begin
            if (!eq_in) begin
                mismatch_count <= mismatch_count + CNT_ONE;
                if (!first_fail_valid) begin
                    first_fail_vec   <= vec_out;
                    first_fail_valid <= 1'b1;
                end
            end
            if (vec_out != LAST_VEC) begin
                vec_out <= vec_out + N_IN'(1);
            end else begin
                pass <= (mismatch_count == '0) && eq_in;
            end
        end
    end

endmodule
